// File: rtl/ex_oitf_pkg.sv
// Shared widths and the OITF entry payload type for the EXU long-pipe tracker.
// The width defines live here so every file that imports the package sees them.
`ifndef E203_OITF_DEPTH
  `define E203_OITF_DEPTH 2
`endif
`ifndef E203_ITAG_WIDTH
  `define E203_ITAG_WIDTH 1
`endif
`ifndef E203_RFIDX_WIDTH
  `define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_PC_SIZE
  `define E203_PC_SIZE 32
`endif

package ex_oitf_pkg;
  localparam int OITF_DEPTH = `E203_OITF_DEPTH;
  localparam int ITAG_W     = `E203_ITAG_WIDTH;
  localparam int RFIDX_W    = `E203_RFIDX_WIDTH;
  localparam int PC_W       = `E203_PC_SIZE;

  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic               rdwen;
    logic               rdfpu;
    logic [PC_W-1:0]    pc;
  } oitf_ent_t;

  // True when a dispatching operand reads the register this entry will write.
  function automatic logic ent_hit(oitf_ent_t e, logic en,
                                   logic [RFIDX_W-1:0] idx, logic fpu);
    return en & e.rdwen & (e.rdidx == idx) & (e.rdfpu == fpu);
  endfunction
endpackage

// File: rtl/ex_oitf_ptr.sv
// Ring pointer with wrap flag; the flag distinguishes full from empty.
module oitf_ptr #(
  parameter int DEPTH = 2,
  parameter int PTRW  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [PTRW-1:0] ptr,
  output logic            flg
);
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic            flg_q, flg_d;

  always_comb begin
    ptr_d = ptr_q;
    flg_d = flg_q;
    if (inc) begin
      if (ptr_q == PTRW'(DEPTH-1)) begin
        ptr_d = '0;
        flg_d = ~flg_q;
      end else begin
        ptr_d = ptr_q + PTRW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      flg_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      flg_q <= flg_d;
    end
  end

  assign ptr = ptr_q;
  assign flg = flg_q;
endmodule

// File: rtl/ex_oitf.sv
// Outstanding instruction track FIFO: in-order alloc/retire of long-pipe ops
// plus RAW/WAW hazard flags against destinations still in flight.
module ex_oitf
  import ex_oitf_pkg::*;
#(
  parameter int DEPTH = `E203_OITF_DEPTH,
  parameter int PTRW  = `E203_ITAG_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dis_ena,
  output logic                         dis_ready,
  output logic [PTRW-1:0]              dis_ptr,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic                         disp_i_rdwen,
  input  logic                         disp_i_rdfpu,
  input  logic [`E203_PC_SIZE-1:0]     disp_i_pc,
  input  logic                         disp_i_rs1en,
  input  logic                         disp_i_rs2en,
  input  logic                         disp_i_rs3en,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [`E203_RFIDX_WIDTH-1:0] disp_i_rs3idx,
  input  logic                         disp_i_rs1fpu,
  input  logic                         disp_i_rs2fpu,
  input  logic                         disp_i_rs3fpu,
  output logic                         oitfrd_match_disprs1,
  output logic                         oitfrd_match_disprs2,
  output logic                         oitfrd_match_disprs3,
  output logic                         oitfrd_match_disprd,
  input  logic                         ret_ena,
  output logic [PTRW-1:0]              ret_ptr,
  output logic [`E203_RFIDX_WIDTH-1:0] ret_rdidx,
  output logic                         ret_rdwen,
  output logic                         ret_rdfpu,
  output logic [`E203_PC_SIZE-1:0]     ret_pc,
  output logic                         oitf_empty
);
  logic [PTRW-1:0]  alc_ptr, rtr_ptr;
  logic             alc_flg, rtr_flg;
  logic             alc, rtr, full;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] m_rs1, m_rs2, m_rs3, m_rd;
  oitf_ent_t        ent_arr [DEPTH];
  oitf_ent_t        new_ent;

  assign oitf_empty = (alc_ptr == rtr_ptr) & (alc_flg == rtr_flg);
  assign full       = (alc_ptr == rtr_ptr) & (alc_flg != rtr_flg);
  assign dis_ready  = ~full;
  assign alc        = dis_ena & dis_ready;
  assign rtr        = ret_ena & ~oitf_empty;
  assign dis_ptr    = alc_ptr;
  assign ret_ptr    = rtr_ptr;

  oitf_ptr #(.DEPTH(DEPTH), .PTRW(PTRW)) u_alc_ptr (
    .clk(clk), .rst_n(rst_n), .inc(alc), .ptr(alc_ptr), .flg(alc_flg)
  );
  oitf_ptr #(.DEPTH(DEPTH), .PTRW(PTRW)) u_rtr_ptr (
    .clk(clk), .rst_n(rst_n), .inc(rtr), .ptr(rtr_ptr), .flg(rtr_flg)
  );

  assign new_ent = '{rdidx: disp_i_rdidx, rdwen: disp_i_rdwen,
                     rdfpu: disp_i_rdfpu, pc: disp_i_pc};

  // alc and rtr never target the same slot: that needs empty or full,
  // and each of those blocks one of the two.
  always_comb begin
    valid_d = valid_q;
    if (alc) valid_d[alc_ptr] = 1'b1;
    if (rtr) valid_d[rtr_ptr] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    oitf_ent_t ent_q, ent_d;
    assign ent_d = (alc && alc_ptr == PTRW'(g)) ? new_ent : ent_q;

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) ent_q <= ent_d;

    assign ent_arr[g] = ent_q;
    // Only entries valid before this edge count; a same-cycle alloc is excluded.
    assign m_rs1[g] = valid_q[g] & ent_hit(ent_q, disp_i_rs1en, disp_i_rs1idx, disp_i_rs1fpu);
    assign m_rs2[g] = valid_q[g] & ent_hit(ent_q, disp_i_rs2en, disp_i_rs2idx, disp_i_rs2fpu);
    assign m_rs3[g] = valid_q[g] & ent_hit(ent_q, disp_i_rs3en, disp_i_rs3idx, disp_i_rs3fpu);
    assign m_rd[g]  = valid_q[g] & ent_hit(ent_q, disp_i_rdwen, disp_i_rdidx,  disp_i_rdfpu);
  end

  assign oitfrd_match_disprs1 = |m_rs1;
  assign oitfrd_match_disprs2 = |m_rs2;
  assign oitfrd_match_disprs3 = |m_rs3;
  assign oitfrd_match_disprd  = |m_rd;

  assign ret_rdidx = ent_arr[rtr_ptr].rdidx;
  assign ret_rdwen = ent_arr[rtr_ptr].rdwen;
  assign ret_rdfpu = ent_arr[rtr_ptr].rdfpu;
  assign ret_pc    = ent_arr[rtr_ptr].pc;
endmodule

// File: tb/tb_ex_oitf.sv
// Randomized + directed bench for ex_oitf against a queue-based FIFO model.
module tb_ex_oitf;
  import ex_oitf_pkg::*;

  localparam int D = OITF_DEPTH;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               dis_ena, dis_ready;
  logic [ITAG_W-1:0]  dis_ptr, ret_ptr;
  logic [RFIDX_W-1:0] disp_i_rdidx, disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, ret_rdidx;
  logic               disp_i_rdwen, disp_i_rdfpu;
  logic [PC_W-1:0]    disp_i_pc, ret_pc;
  logic               disp_i_rs1en, disp_i_rs2en, disp_i_rs3en;
  logic               disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu;
  logic               m_rs1, m_rs2, m_rs3, m_rd;
  logic               ret_ena, ret_rdwen, ret_rdfpu, oitf_empty;

  int n_chk = 0;
  int n_fail = 0;

  oitf_ent_t q[$];
  int        head_cnt, tail_cnt;

  ex_oitf dut (
    .clk(clk), .rst_n(rst_n), .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
    .disp_i_rdidx(disp_i_rdidx), .disp_i_rdwen(disp_i_rdwen), .disp_i_rdfpu(disp_i_rdfpu),
    .disp_i_pc(disp_i_pc),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rs3en(disp_i_rs3en),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rs3idx(disp_i_rs3idx),
    .disp_i_rs1fpu(disp_i_rs1fpu), .disp_i_rs2fpu(disp_i_rs2fpu), .disp_i_rs3fpu(disp_i_rs3fpu),
    .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
    .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd),
    .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx), .ret_rdwen(ret_rdwen),
    .ret_rdfpu(ret_rdfpu), .ret_pc(ret_pc), .oitf_empty(oitf_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mdl_hit(bit en, logic [RFIDX_W-1:0] idx, bit fpu);
    foreach (q[i]) if (en && q[i].rdwen && q[i].rdidx == idx && q[i].rdfpu == fpu) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mdl_clear();
    q.delete();
    head_cnt = 0;
    tail_cnt = 0;
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic check_all();
    #1;
    chk("empty", oitf_empty, q.size() == 0);
    chk("dis_ready", dis_ready, q.size() < D);
    chk("dis_ptr", dis_ptr, tail_cnt % D);
    chk("ret_ptr", ret_ptr, head_cnt % D);
    if (q.size() != 0) begin
      chk("ret_pc", ret_pc, q[0].pc);
      chk("ret_rdidx", ret_rdidx, q[0].rdidx);
      chk("ret_rdwen", ret_rdwen, q[0].rdwen);
      chk("ret_rdfpu", ret_rdfpu, q[0].rdfpu);
    end
    chk("m_rs1", m_rs1, mdl_hit(disp_i_rs1en, disp_i_rs1idx, disp_i_rs1fpu));
    chk("m_rs2", m_rs2, mdl_hit(disp_i_rs2en, disp_i_rs2idx, disp_i_rs2fpu));
    chk("m_rs3", m_rs3, mdl_hit(disp_i_rs3en, disp_i_rs3idx, disp_i_rs3fpu));
    chk("m_rd", m_rd, mdl_hit(disp_i_rdwen, disp_i_rdidx, disp_i_rdfpu));
  endtask

  // One clock: check, take the edge, advance the model, return at negedge.
  task automatic cyc();
    bit alc, rtr;
    oitf_ent_t e;
    check_all();
    alc = dis_ena && q.size() < D;
    rtr = ret_ena && q.size() > 0;
    e = '{rdidx: disp_i_rdidx, rdwen: disp_i_rdwen, rdfpu: disp_i_rdfpu, pc: disp_i_pc};
    @(posedge clk);
    if (rtr) begin void'(q.pop_front()); head_cnt++; end
    if (alc) begin q.push_back(e); tail_cnt++; end
    @(negedge clk);
  endtask

  task automatic idle();
    dis_ena = 0; ret_ena = 0;
    disp_i_rdidx = '0; disp_i_rdwen = 0; disp_i_rdfpu = 0; disp_i_pc = '0;
    disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs3en = 0;
    disp_i_rs1idx = '0; disp_i_rs2idx = '0; disp_i_rs3idx = '0;
    disp_i_rs1fpu = 0; disp_i_rs2fpu = 0; disp_i_rs3fpu = 0;
  endtask

  task automatic drv(input bit ena, input bit ret, input int rd, input bit wen, input int pc);
    dis_ena = ena; ret_ena = ret;
    disp_i_rdidx = RFIDX_W'(rd); disp_i_rdwen = wen; disp_i_rdfpu = 0;
    disp_i_pc = PC_W'(pc);
  endtask

  initial begin
    idle();
    mdl_clear();
    rst_n = 0;
    #12;
    // 1: reset state and ignored retire while empty
    chk("rst_empty", oitf_empty, 1'b1);
    chk("rst_ready", dis_ready, 1'b1);
    chk("rst_dis_ptr", dis_ptr, 0);
    chk("rst_ret_ptr", ret_ptr, 0);
    chk("rst_match", {m_rs1, m_rs2, m_rs3, m_rd}, 4'b0);
    @(negedge clk); rst_n = 1;
    ret_ena = 1; cyc(); cyc();
    #1 chk("idle_ret_ptr", ret_ptr, 0);
    chk("idle_empty", oitf_empty, 1'b1);

    // 2: fill to full
    drv(1, 0, 5, 1, 'h100); #1 chk("fill_ptr0", dis_ptr, 0); cyc();
    drv(1, 0, 6, 1, 'h104); #1 chk("fill_ptr1", dis_ptr, 1); cyc();
    idle(); #1;
    chk("full_ready", dis_ready, 1'b0);
    chk("full_pc", ret_pc, 'h100);
    chk("full_rd", ret_rdidx, 5);

    // 3: drain with wrap
    ret_ena = 1; cyc();
    #1 chk("drain_pc", ret_pc, 'h104);
    cyc();
    #1 chk("drain_empty", oitf_empty, 1'b1);
    drv(1, 0, 7, 1, 'h200); #1 chk("wrap_ptr", dis_ptr, 0); cyc();
    idle(); #1 chk("wrap_ready", dis_ready, 1'b1);
    chk("wrap_pc", ret_pc, 'h200);

    // 4: simultaneous alloc + retire with one entry
    drv(1, 1, 8, 1, 'h204); cyc();
    idle(); #1;
    chk("sim_rd", ret_rdidx, 8);
    chk("sim_empty", oitf_empty, 1'b0);
    chk("sim_ready", dis_ready, 1'b1);

    // 5: hazard flags
    drv(1, 1, 3, 1, 'h300); cyc();
    idle();
    disp_i_rs1en = 1; disp_i_rs1idx = 3; #1 chk("haz_rs1", m_rs1, 1'b1);
    disp_i_rs2en = 0; disp_i_rs2idx = 3; #1 chk("haz_rs2_off", m_rs2, 1'b0);
    disp_i_rs1fpu = 1; #1 chk("haz_fpu", m_rs1, 1'b0);
    idle(); drv(1, 1, 4, 0, 'h304); cyc();
    idle(); disp_i_rs1en = 1; disp_i_rs1idx = 4; #1 chk("haz_nowen", m_rs1, 1'b0);
    idle(); ret_ena = 1; cyc();
    idle(); drv(1, 0, 3, 1, 'h308); disp_i_rs1en = 1; disp_i_rs1idx = 3;
    #1 chk("haz_self_rs1", m_rs1, 1'b0);
    chk("haz_self_rd", m_rd, 1'b0);
    cyc();

    // 6: asynchronous reset while full
    idle(); drv(1, 0, 3, 1, 'h30c); cyc();
    idle(); disp_i_rs1en = 1; disp_i_rs1idx = 3; disp_i_rdwen = 1; disp_i_rdidx = 3;
    #1 chk("pre_rst_full", dis_ready, 1'b0);
    #1 rst_n = 0;
    #1;
    chk("arst_empty", oitf_empty, 1'b1);
    chk("arst_match", {m_rs1, m_rs2, m_rs3, m_rd}, 4'b0);
    chk("arst_ready", dis_ready, 1'b1);
    mdl_clear();
    @(negedge clk); rst_n = 1;
    idle();

    // Random traffic with a narrow register range so hazards hit often
    for (int i = 0; i < 400; i++) begin
      dis_ena = ($urandom_range(0, 3) != 0);
      ret_ena = ($urandom_range(0, 2) != 0);
      disp_i_rdidx = RFIDX_W'($urandom_range(0, 3));
      disp_i_rdwen = $urandom_range(0, 1);
      disp_i_rdfpu = ($urandom_range(0, 3) == 0);
      disp_i_pc = PC_W'($urandom);
      disp_i_rs1en = $urandom_range(0, 1);
      disp_i_rs2en = $urandom_range(0, 1);
      disp_i_rs3en = $urandom_range(0, 1);
      disp_i_rs1idx = RFIDX_W'($urandom_range(0, 3));
      disp_i_rs2idx = RFIDX_W'($urandom_range(0, 3));
      disp_i_rs3idx = RFIDX_W'($urandom_range(0, 3));
      disp_i_rs1fpu = ($urandom_range(0, 3) == 0);
      disp_i_rs2fpu = ($urandom_range(0, 3) == 0);
      disp_i_rs3fpu = ($urandom_range(0, 3) == 0);
      cyc();
    end
    idle();
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
